// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and negate helper for the iterative
// multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MULTU = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  // Widest value the negate helper handles; callers size-cast in and out.
  localparam int MD_MAXW = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  function automatic logic [MD_MAXW-1:0] md_negate(input logic [MD_MAXW-1:0] v,
                                                  input logic               en);
    logic [MD_MAXW-1:0] r;
    if (en) begin
      r = (~v) + {{(MD_MAXW-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step,
// operating on a {hi(WIDTH+1), lo(WIDTH)} working pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH+1:0] diff_s;

  // Multiply shifts right after a conditional add; divide shifts left and keeps the difference when no borrow.
  always_comb begin
    sum_s    = hi_i + {1'b0, m_i};
    rem_sh_s = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
    diff_s   = {1'b0, rem_sh_s} - {2'b00, m_i};
    if (lo_i[0]) begin
      add_s = sum_s;
    end else begin
      add_s = hi_i;
    end
    if (div_i) begin
      if (diff_s[WIDTH+1]) begin
        hi_o = rem_sh_s;
      end else begin
        hi_o = diff_s[WIDTH:0];
      end
      lo_o = {lo_i[WIDTH-2:0], ~diff_s[WIDTH+1]};
    end else begin
      hi_o = {1'b0, add_s[WIDTH:1]};
      lo_o = {add_s[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers and a
// start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              W2       = 2 * WIDTH;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d, m_q, m_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;

  logic [WIDTH:0]   step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic             sgn_a_s, sgn_b_s, b_zero_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s, quo_s, rem_s;
  logic [W2-1:0]    prod_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .hi_i  (acc_hi_q),
    .lo_i  (acc_lo_q),
    .m_i   (m_q),
    .hi_o  (step_hi_s),
    .lo_o  (step_lo_s)
  );

  // Operand magnitudes at accept and sign-corrected results at fix-up.
  always_comb begin
    sgn_a_s  = op[0] & a[WIDTH-1];
    sgn_b_s  = op[0] & b[WIDTH-1];
    b_zero_s = (b == {WIDTH{1'b0}});
    mag_a_s  = WIDTH'(md_negate(MD_MAXW'(a), sgn_a_s));
    mag_b_s  = WIDTH'(md_negate(MD_MAXW'(b), sgn_b_s));
    prod_s   = W2'(md_negate(MD_MAXW'({acc_hi_q[WIDTH-1:0], acc_lo_q}), neg_q));
    quo_s    = WIDTH'(md_negate(MD_MAXW'(acc_lo_q), neg_q));
    rem_s    = WIDTH'(md_negate(MD_MAXW'(acc_hi_q[WIDTH-1:0]), rneg_q));
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNTW{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      acc_hi_q <= {(WIDTH+1){1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      m_q      <= {WIDTH{1'b0}};
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
    end
  end

  // Next-state logic: only multiply/divide codes leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !op[2]) begin
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath/output next values; a zero divisor suppresses quotient negation so lo stays all ones.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          case (op)
            MD_MULTU, MD_MULT, MD_DIVU, MD_DIV: begin
              cnt_d    = {CNTW{1'b0}};
              div_d    = op[1];
              neg_d    = (sgn_a_s ^ sgn_b_s) & ~(op[1] & b_zero_s);
              rneg_d   = sgn_a_s;
              bz_d     = b_zero_s;
              acc_hi_d = {(WIDTH+1){1'b0}};
              if (op[1]) begin
                acc_lo_d = mag_a_s;
                m_d      = mag_b_s;
              end else begin
                acc_lo_d = mag_b_s;
                m_d      = mag_a_s;
              end
            end
            MD_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            MD_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: begin
            end
          endcase
        end else begin
          dbz_d = dbz_q;
        end
      end
      ST_CALC: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        cnt_d    = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
      ST_FIX: begin
        done_d = 1'b1;
        dbz_d  = div_q & bz_q;
        if (div_q) begin
          lo_d = quo_s;
          hi_d = rem_s;
        end else begin
          hi_d = prod_s[W2-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width.
- Sits beside the combinational ALU in the EX stage and implements MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Uses a start/busy/done handshake; the pipeline stalls on busy and reads HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4.
- CNTW, $clog2(WIDTH)+1, iteration-counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  request; accepted only when busy=0.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
- a  in  WIDTH  operand A (multiplicand / dividend / MT source).
- b  in  WIDTH  operand B (multiplier / divisor).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO updated this cycle.
- div_by_zero  out  1  last completed divide had b=0; held until next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset wins over start and aborts any in-flight operation; no partial result is written.
- FSM states: IDLE, CALC, FIX. busy = (state != IDLE). busy is registered state, not a combinational function of start.
- Accept: at edge k with state=IDLE and start=1, a, b and op are captured; later operand changes have no effect. div_by_zero clears at accept.
- MTHI/MTLO: at edge k, hi<=a (or lo<=a); done=1 for the cycle after edge k; state stays IDLE; busy is never raised.
- No-op codes: accepted, ignored. No done pulse, no state change.
- MUL/DIV sequence:
  - Edge k: IDLE->CALC, count=0, operand magnitudes loaded. Signed ops take |a| and |b| and record the signs.
  - Edges k+1..k+WIDTH: one radix-2 step per edge. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring shift-subtract. At edge k+WIDTH, CALC->FIX.
  - Edge k+WIDTH+1: sign fix-up; hi/lo written; done=1 for exactly one cycle; FIX->IDLE.
  - Latency: busy is high in cycles k+1..k+WIDTH+1. done and the new hi/lo are visible in cycle k+WIDTH+2. hi/lo keep their old values until that cycle.
- Back-to-back: start may be asserted in the done cycle (state IDLE) and is accepted.
- start while busy=1: ignored, with no effect on the operation.
- Multiply result: {hi,lo} = full 2*WIDTH product. Signed ops negate the product when sign(a)^sign(b).
- Divide result: lo = quotient, hi = remainder. Signed ops truncate toward zero: quotient sign = sign(a)^sign(b), remainder sign = sign(a).
- Signed overflow (MIN / -1): lo=MIN, hi=0.
- Divide by zero: no trap. Full latency still applies. Result is lo = all ones and hi = a (the natural restoring result, before sign fix for signed ops; for DIV with b=0, lo=all ones and hi=a regardless of sign). div_by_zero=1 from the done cycle.
- All widths are handled in WIDTH or 2*WIDTH precision with no truncation of intermediates. The accumulator/remainder register is WIDTH+1 bits to hold the subtract borrow.

Decomposition:
- Package muldiv_pkg:
  - op encodings MD_MULTU..MD_MTLO;
  - FSM state enum (IDLE/CALC/FIX);
  - helper negate function.
- Sub-module muldiv_step: combinational single-iteration datapath (mul-add or div-subtract selected by a mode bit), instantiated once.
- FSM, counter and HI/LO registers live in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. busy high exactly 33 cycles; done 34 cycles after the start edge.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1. A following MTLO a=0x1234 -> div_by_zero=0, lo=0x1234, done after 1 cycle, hi=5 unchanged.
- start with a new op during busy -> ignored; original result correct. start in the done cycle -> accepted, busy next cycle.
- rst_n=0 at CALC count 10 -> next cycle busy=0, done=0, hi=lo=0. No done pulse afterwards.
